// File: rtl/ps2_scan_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_scan_rx_if
// Output bundle of the PS/2 receive front end: make codes and status pulses
// handed to the command/LED control stage.
//
// Signals:
//   PS2_Done_Sig  one-cycle pulse, new make code present on PS2_Data
//   PS2_Data      last accepted make code, held between pulses
//   PS2_Ext_Sig   PS2_Data was E0-prefixed, updated together with Done
//   PS2_Err_Sig   one-cycle pulse, frame error or mid-frame timeout
//
// Modports:
//   master  receiver side (drives the bundle)
//   slave   consumer side
// ---------------------------------------------------------------------------
interface ps2_scan_rx_if;
    logic       PS2_Done_Sig;
    logic [7:0] PS2_Data;
    logic       PS2_Ext_Sig;
    logic       PS2_Err_Sig;

    modport master (
        output PS2_Done_Sig,
        output PS2_Data,
        output PS2_Ext_Sig,
        output PS2_Err_Sig
    );

    modport slave (
        input PS2_Done_Sig,
        input PS2_Data,
        input PS2_Ext_Sig,
        input PS2_Err_Sig
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// ---------------------------------------------------------------------------
// ps2_scan_rx
// PS/2 keyboard receive front end. Synchronises the raw pad pins, debounces
// the PS/2 clock, deframes 11-bit device-to-host frames and strips the F0
// (break) and E0 (extended) prefixes. Only make codes reach the output;
// release codes are swallowed.
//
// Ports:
//   CLK          system clock, all logic on rising edge
//   RST          synchronous reset, active-high, overrides everything
//   PS2_CLK_Pin  raw PS/2 clock from pad (asynchronous)
//   PS2_DAT_Pin  raw PS/2 data from pad (asynchronous)
//   code_bus     make code / done / ext / error outputs (master modport)
//
// Parameters:
//   FILTER_LEN      identical synced samples needed to move the filtered
//                   clock level (2..255)
//   TIMEOUT_CYCLES  idle cycles tolerated mid-frame before abort
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a start bit (falling edge with data low)
//   RECV  | shifting in bits 2..11, timeout counter running
//   CHECK | one cycle: validate frame, handle prefixes, emit code or error
// ---------------------------------------------------------------------------
module ps2_scan_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                PS2_CLK_Pin,
    input  logic                PS2_DAT_Pin,
    ps2_scan_rx_if.master       code_bus
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]      FILT_TC = 8'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0] TO_TC   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // -----------------------------------------------------------------------
    logic       clk_s1, clk_s2;
    logic       dat_s1, dat_s2;
    logic       filt_clk;
    logic [7:0] filt_cnt;
    logic       sample;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            filt_clk <= 1'b1;
            filt_cnt <= 8'd0;
        end else begin
            clk_s1 <= PS2_CLK_Pin;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DAT_Pin;
            dat_s2 <= dat_s1;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == FILT_TC) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= 8'd0;
                end else begin
                    filt_cnt <= filt_cnt + 8'd1;
                end
            end else begin
                filt_cnt <= 8'd0;
            end
        end
    end

    // Fires in the cycle the filtered clock is about to drop; data is taken
    // from the synced pin in the same cycle, so both paths see equal delay.
    assign sample = filt_clk && !clk_s2 && (filt_cnt == FILT_TC);

    // -----------------------------------------------------------------------
    // Deframer FSM
    // -----------------------------------------------------------------------
    state_t          state, state_n;
    logic [3:0]      bit_cnt, bit_cnt_n;
    logic [10:0]     frame, frame_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;
    logic            break_pend, break_pend_n;
    logic            ext_pend, ext_pend_n;
    logic [7:0]      data_q, data_n;
    logic            ext_q, ext_n;
    logic            done_q, done_n;
    logic            err_q, err_n;

    logic [7:0]      code;
    logic            frame_ok;

    // frame[0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
    assign code     = frame[8:1];
    assign frame_ok = !frame[0] && (^frame[9:1]) && frame[10];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            frame      <= 11'd0;
            to_cnt     <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            data_q     <= 8'h00;
            ext_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            frame      <= frame_n;
            to_cnt     <= to_cnt_n;
            break_pend <= break_pend_n;
            ext_pend   <= ext_pend_n;
            data_q     <= data_n;
            ext_q      <= ext_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        frame_n      = frame;
        to_cnt_n     = to_cnt;
        break_pend_n = break_pend;
        ext_pend_n   = ext_pend;
        data_n       = data_q;
        ext_n        = ext_q;
        done_n       = 1'b0;
        err_n        = 1'b0;

        case (state)
            IDLE: begin
                to_cnt_n = '0;
                if (sample && !dat_s2) begin
                    frame_n   = {dat_s2, frame[10:1]};
                    bit_cnt_n = 4'd1;
                    state_n   = RECV;
                end
            end

            RECV: begin
                if (sample) begin
                    frame_n   = {dat_s2, frame[10:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    to_cnt_n  = '0;
                    if (bit_cnt == 4'd10) begin
                        state_n = CHECK;
                    end
                end else if (to_cnt == TO_TC) begin
                    err_n        = 1'b1;
                    break_pend_n = 1'b0;
                    ext_pend_n   = 1'b0;
                    to_cnt_n     = '0;
                    state_n      = IDLE;
                end else begin
                    to_cnt_n = to_cnt + TO_ONE;
                end
            end

            CHECK: begin
                state_n = IDLE;
                if (!frame_ok) begin
                    err_n        = 1'b1;
                    break_pend_n = 1'b0;
                    ext_pend_n   = 1'b0;
                end else if (code == CODE_BREAK) begin
                    break_pend_n = 1'b1;
                end else if (code == CODE_EXT) begin
                    ext_pend_n = 1'b1;
                end else if (break_pend) begin
                    // Release of a key: drop it along with any E0 before it.
                    break_pend_n = 1'b0;
                    ext_pend_n   = 1'b0;
                end else begin
                    data_n     = code;
                    ext_n      = ext_pend;
                    done_n     = 1'b1;
                    ext_pend_n = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign code_bus.PS2_Done_Sig = done_q;
    assign code_bus.PS2_Data     = data_q;
    assign code_bus.PS2_Ext_Sig  = ext_q;
    assign code_bus.PS2_Err_Sig  = err_q;

endmodule
